bitreverse_in: RTL and testbench

Input-side reorderer for a radix-2 DIT FFT. It accepts frames of N=2^LGSIZE complex samples in natural order, two per clock, and emits each frame in bit-reversed order, two per clock.
- Uses ping-pong even/odd lane banks, so streaming is continuous after one frame of fill latency.
- Sits between the sample source and the first DIT butterfly stage.
- Adds an input frame sync and a frame-lock state machine.

---
 rtl/bitreverse_in.sv | 142 ++++++++++++++
 tb/tb_bitreverse_in.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitreverse_in.sv
// Input-side bit-reversal reorderer for a radix-2 DIT FFT: two natural-order samples in,
// two bit-reversed-order samples out per enabled clock, with frame sync and frame lock.
module bitreverse_in #(
  parameter int LGSIZE = 5,
  parameter int WIDTH  = 24
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_clk_enable,
  input  logic               i_sync,
  input  logic [2*WIDTH-1:0] i_in_0,
  input  logic [2*WIDTH-1:0] i_in_1,
  output logic [2*WIDTH-1:0] o_out_0,
  output logic [2*WIDTH-1:0] o_out_1,
  output logic               o_sync,
  output logic               o_valid
);

  localparam int N  = 1 << LGSIZE;
  localparam int CW = LGSIZE - 1;
  localparam logic [CW-1:0] N_ZERO = '0;
  localparam logic [CW-1:0] N_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] N_LAST = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t        state_r, state_nx_s;
  logic [CW-1:0] n_r, n_nx_s;
  logic          wb_r, wb_nx_s;
  logic          resync_s;
  logic          wr_en_s;
  logic [CW-1:0] wr_n_s;
  logic [CW-1:0] rd_r_s;
  logic [LGSIZE-1:0] rd_lo_s, rd_hi_s;

  logic [2*WIDTH-1:0] mem_even [N];
  logic [2*WIDTH-1:0] mem_odd  [N];

  function automatic logic [CW-1:0] bitrev(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    for (int i = 0; i < CW; i++) begin
      r[i] = v[CW-1-i];
    end
    return r;
  endfunction

  // Frame-lock next-state, counter, half-select and write control
  always_comb begin
    state_nx_s = state_r;
    n_nx_s     = n_r;
    wb_nx_s    = wb_r;
    resync_s   = 1'b0;
    wr_en_s    = 1'b0;
    wr_n_s     = n_r;
    case (state_r)
      IDLE: begin
        if (i_sync) begin
          wr_en_s    = 1'b1;
          wr_n_s     = N_ZERO;
          n_nx_s     = N_ONE;
          state_nx_s = FILL;
        end else begin
          state_nx_s = IDLE;
        end
      end
      FILL: begin
        wr_en_s = 1'b1;
        if (i_sync && (n_r != N_ZERO)) begin
          wr_n_s = N_ZERO;
          n_nx_s = N_ONE;
        end else if (n_r == N_LAST) begin
          n_nx_s     = N_ZERO;
          wb_nx_s    = ~wb_r;
          state_nx_s = RUN;
        end else begin
          n_nx_s = n_r + N_ONE;
        end
      end
      RUN: begin
        wr_en_s = 1'b1;
        if (i_sync && (n_r != N_ZERO)) begin
          // Misaligned sync: drop lock and refill from this pair
          resync_s   = 1'b1;
          wr_n_s     = N_ZERO;
          n_nx_s     = N_ONE;
          state_nx_s = FILL;
        end else if (n_r == N_LAST) begin
          n_nx_s  = N_ZERO;
          wb_nx_s = ~wb_r;
        end else begin
          n_nx_s = n_r + N_ONE;
        end
      end
      default: begin
        state_nx_s = IDLE;
        n_nx_s     = N_ZERO;
        wb_nx_s    = 1'b0;
      end
    endcase
  end

  // x[r] and x[r+N/2] share bank r&1; the upper one sits P/2 pairs further in
  always_comb begin
    rd_r_s  = bitrev(n_r);
    rd_lo_s = {~wb_r, 1'b0, rd_r_s[CW-1:1]};
    rd_hi_s = {~wb_r, 1'b1, rd_r_s[CW-1:1]};
  end

  // Lane banks, written into the half selected by wb
  always_ff @(posedge i_clk) begin
    if (i_clk_enable && wr_en_s) begin
      mem_even[{wb_r, wr_n_s}] <= i_in_0;
      mem_odd[{wb_r, wr_n_s}]  <= i_in_1;
    end
  end

  // Control state and registered outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r <= IDLE;
      n_r     <= N_ZERO;
      wb_r    <= 1'b0;
      o_valid <= 1'b0;
      o_sync  <= 1'b0;
      o_out_0 <= '0;
      o_out_1 <= '0;
    end else if (i_clk_enable) begin
      state_r <= state_nx_s;
      n_r     <= n_nx_s;
      wb_r    <= wb_nx_s;
      o_valid <= (state_r == RUN) && !resync_s;
      o_sync  <= (state_r == RUN) && !resync_s && (n_r == N_ZERO);
      o_out_0 <= rd_r_s[0] ? mem_odd[rd_lo_s] : mem_even[rd_lo_s];
      o_out_1 <= rd_r_s[0] ? mem_odd[rd_hi_s] : mem_even[rd_hi_s];
    end
  end

endmodule

// File: tb/tb_bitreverse_in.sv
// Bench for bitreverse_in: table-driven LGSIZE=3 sequences with a frame-level scoreboard,
// reset/resync corner cases, and a random LGSIZE=5 run.
module tb_bitreverse_in;

  localparam int W  = 8;
  localparam int SW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n, en;
  logic          s3, s5;
  logic [SW-1:0] a3, b3, a5, b5;
  logic [SW-1:0] o3_0, o3_1, o5_0, o5_1;
  logic          os3, ov3, os5, ov5;

  always #5 clk = ~clk;

  bitreverse_in #(.LGSIZE(3), .WIDTH(W)) u3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_clk_enable(en), .i_sync(s3),
    .i_in_0(a3), .i_in_1(b3), .o_out_0(o3_0), .o_out_1(o3_1),
    .o_sync(os3), .o_valid(ov3)
  );

  bitreverse_in #(.LGSIZE(5), .WIDTH(W)) u5 (
    .i_clk(clk), .i_reset_n(rst_n), .i_clk_enable(en), .i_sync(s5),
    .i_in_0(a5), .i_in_1(b5), .o_out_0(o5_0), .o_out_1(o5_1),
    .o_sync(os5), .o_valid(ov5)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int brev(input int v, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) begin
      if (v[i]) r = r | (1 << (bits - 1 - i));
    end
    return r;
  endfunction

  // Frame-level scoreboard for the LGSIZE=3 instance
  typedef enum {M_IDLE, M_FILL, M_RUN} mstate_t;
  typedef struct packed {
    logic [SW-1:0] d0;
    logic [SW-1:0] d1;
  } pair_t;

  mstate_t       ms;
  int            mn;
  logic [SW-1:0] cur [8];
  pair_t         q [$];
  logic [SW-1:0] p0, p1;
  logic          pv, ps;

  task automatic model_reset();
    ms = M_IDLE;
    mn = 0;
    q.delete();
    pv = 1'b0; ps = 1'b0; p0 = '0; p1 = '0;
  endtask

  task automatic push_frame();
    for (int m = 0; m < 4; m++) begin
      q.push_back('{d0: cur[brev(2*m, 3)], d1: cur[brev(2*m+1, 3)]});
    end
  endtask

  task automatic step3(input logic e, input logic s, input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic  xv, xs;
    pair_t ex;
    @(negedge clk);
    en = e; s3 = s; a3 = a; b3 = b; s5 = 1'b0; a5 = '0; b5 = '0;
    @(posedge clk);
    #1;
    if (e) begin
      xv = (ms == M_RUN) && !(s && mn != 0);
      xs = xv && (mn == 0);
      chk("sb_valid", 32'(ov3), 32'(xv));
      chk("sb_sync", 32'(os3), 32'(xs));
      if (xv) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_queue: valid output %0h/%0h with nothing expected", o3_0, o3_1);
        end else begin
          ex = q.pop_front();
          chk("sb_out0", 32'(o3_0), 32'(ex.d0));
          chk("sb_out1", 32'(o3_1), 32'(ex.d1));
        end
      end
      if (ms == M_IDLE) begin
        if (s) begin
          cur[0] = a; cur[1] = b; mn = 1; ms = M_FILL;
        end
      end else if (s && mn != 0) begin
        q.delete();
        cur[0] = a; cur[1] = b; mn = 1; ms = M_FILL;
      end else begin
        cur[2*mn] = a; cur[2*mn+1] = b;
        if (mn == 3) begin
          push_frame();
          mn = 0;
          ms = M_RUN;
        end else begin
          mn++;
        end
      end
    end else begin
      chk("hold_valid", 32'(ov3), 32'(pv));
      chk("hold_sync", 32'(os3), 32'(ps));
      chk("hold_out0", 32'(o3_0), 32'(p0));
      chk("hold_out1", 32'(o3_1), 32'(p1));
    end
    pv = ov3; ps = os3; p0 = o3_0; p1 = o3_1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; s3 = 1'b0; s5 = 1'b0;
    #2;
    chk("rst_valid3", 32'(ov3), 32'd0);
    chk("rst_sync3", 32'(os3), 32'd0);
    chk("rst_out3", 32'({o3_0, o3_1}), 32'd0);
    chk("rst_valid5", 32'(ov5), 32'd0);
    chk("rst_sync5", 32'(os5), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Hand-derived expectations for three frames x[i]=8f+i
  typedef struct {
    logic          s;
    logic [SW-1:0] a, b;
    logic          xv, xs;
    logic [SW-1:0] x0, x1;
  } vec_t;

  vec_t tv [12];

  task automatic run_table(input bit gaps);
    for (int i = 0; i < 12; i++) begin
      step3(1'b1, tv[i].s, tv[i].a, tv[i].b);
      chk("tbl_valid", 32'(ov3), 32'(tv[i].xv));
      chk("tbl_sync", 32'(os3), 32'(tv[i].xs));
      if (tv[i].xv) begin
        chk("tbl_out0", 32'(o3_0), 32'(tv[i].x0));
        chk("tbl_out1", 32'(o3_1), 32'(tv[i].x1));
      end
      if (gaps) step3(1'b0, 1'b1, 16'hdead, 16'hbeef);
    end
  endtask

  task automatic frame3(input int base, input int npairs);
    for (int p = 0; p < npairs; p++) begin
      step3(1'b1, p == 0, 16'(base + 2*p), 16'(base + 2*p + 1));
    end
  endtask

  logic [SW-1:0] x5 [4][32];
  int            nsync5;

  initial begin
    int e0 [4] = '{0, 2, 1, 3};
    int e1 [4] = '{4, 6, 5, 7};

    rst_n = 1'b0; en = 1'b0; s3 = 1'b0; s5 = 1'b0;
    a3 = '0; b3 = '0; a5 = '0; b5 = '0;
    model_reset();

    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < 4; p++) begin
        tv[4*f+p].s  = (p == 0);
        tv[4*f+p].a  = 16'(8*f + 2*p);
        tv[4*f+p].b  = 16'(8*f + 2*p + 1);
        tv[4*f+p].xv = (f >= 1);
        tv[4*f+p].xs = (f >= 1) && (p == 0);
        tv[4*f+p].x0 = 16'(8*(f-1) + e0[p]);
        tv[4*f+p].x1 = 16'(8*(f-1) + e1[p]);
      end
    end

    // 1: continuous stream
    do_reset();
    run_table(1'b0);

    // 2: enable toggling, junk presented on disabled cycles
    do_reset();
    run_table(1'b1);

    // 3: data before any sync, then locked stream
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step3(1'b1, 1'b0, 16'($urandom), 16'($urandom));
    end
    run_table(1'b0);

    // 4: misaligned sync at n=2 while running
    do_reset();
    frame3(100, 4);
    frame3(200, 2);
    step3(1'b1, 1'b1, 16'd300, 16'd301);
    chk("t4_valid_drop", 32'(ov3), 32'd0);
    for (int k = 1; k < 4; k++) begin
      step3(1'b1, 1'b0, 16'(300 + 2*k), 16'(301 + 2*k));
      chk("t4_no_sync", 32'(os3), 32'd0);
    end
    step3(1'b1, 1'b1, 16'd400, 16'd401);
    chk("t4_sync_lat", 32'(os3), 32'd1);
    chk("t4_first0", 32'(o3_0), 32'd300);
    chk("t4_first1", 32'(o3_1), 32'd304);
    for (int p = 1; p < 4; p++) begin
      step3(1'b1, 1'b0, 16'(400 + 2*p), 16'(401 + 2*p));
    end
    frame3(500, 4);

    // 5: asynchronous reset mid-run
    do_reset();
    frame3(16, 4);
    frame3(24, 2);
    chk("t5_running", 32'(ov3), 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_valid", 32'(ov3), 32'd0);
    chk("t5_sync", 32'(os3), 32'd0);
    chk("t5_out0", 32'(o3_0), 32'd0);
    chk("t5_out1", 32'(o3_1), 32'd0);
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step3(1'b1, 1'b0, 16'($urandom), 16'($urandom));
    end
    frame3(40, 4);
    frame3(48, 4);
    frame3(56, 4);

    // 6: LGSIZE=5, three random frames plus one trailing frame
    do_reset();
    nsync5 = 0;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 32; i++) begin
        x5[f][i] = 16'($urandom);
      end
    end
    for (int f = 0; f < 4; f++) begin
      for (int p = 0; p < 16; p++) begin
        int ed, of, m;
        @(negedge clk);
        en = 1'b1; s3 = 1'b0; s5 = (p == 0);
        a5 = x5[f][2*p]; b5 = x5[f][2*p+1];
        @(posedge clk);
        #1;
        ed = f*16 + p;
        if (os5) nsync5++;
        if (ed >= 16) begin
          of = (ed - 16) / 16;
          m  = (ed - 16) % 16;
          chk("t6_valid", 32'(ov5), 32'd1);
          chk("t6_sync", 32'(os5), 32'(m == 0));
          chk("t6_out0", 32'(o5_0), 32'(x5[of][brev(2*m, 5)]));
          chk("t6_out1", 32'(o5_1), 32'(x5[of][brev(2*m+1, 5)]));
        end else begin
          chk("t6_fill_valid", 32'(ov5), 32'd0);
          chk("t6_fill_sync", 32'(os5), 32'd0);
        end
      end
    end
    chk("t6_sync_count", 32'(nsync5), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
